// File: rtl/dram_cache_pkg.sv
// Shared types and address/byte-lane helpers for the direct-mapped write-through cache.
package dram_cache_pkg;

  localparam int INDEX_BITS = 8;
  localparam int WORD_BITS  = 2;
  localparam int TAG_BITS   = 32 - 2 - WORD_BITS - INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    RF_ISSUE = 3'd2,
    RF_WAIT  = 3'd3,
    RF_RESP  = 3'd4,
    WR_ISSUE = 3'd5,
    WR_WAIT  = 3'd6
  } state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_wr_t;

  function automatic logic [1:0] addr_off(input logic [31:0] a);
    return a[1:0];
  endfunction

  function automatic logic [WORD_BITS-1:0] addr_word(input logic [31:0] a);
    return a[2 +: WORD_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [31:0] a);
    return a[2+WORD_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_BITS];
  endfunction

  // Store data is LSB-aligned; lanes pushed above byte 3 are simply dropped.
  function automatic lane_wr_t lane_merge(input logic [31:0] wdata, input logic [3:0] we,
                                          input logic [1:0] off);
    lane_wr_t r;
    r.be   = we << off;
    r.data = wdata << {off, 3'b000};
    return r;
  endfunction

endpackage

// File: rtl/dram_cache_ram.sv
// Synchronous-read line storage: byte-writable data words plus one tag per line, no reset.
module dram_cache_ram
  import dram_cache_pkg::*;
(
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [WORD_BITS-1:0]  rd_word,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [WORD_BITS-1:0]  wr_word,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data,
  input  logic                  tag_we,
  input  logic [TAG_BITS-1:0]   wr_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int DEPTH = 1 << (INDEX_BITS + WORD_BITS);

  logic [3:0][7:0]      data_mem_r [DEPTH];
  logic [TAG_BITS-1:0]  tag_mem_r  [LINES];

  // Byte-enabled writes and registered reads for both arrays.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) data_mem_r[{wr_idx, wr_word}][b] <= wr_data[8*b +: 8];
    end
    if (tag_we) tag_mem_r[wr_idx] <= wr_tag;
    rd_data <= data_mem_r[{rd_idx, rd_word}];
    rd_tag  <= tag_mem_r[rd_idx];
  end

endmodule

// File: rtl/dram_cache.sv
// Direct-mapped, write-through, no-write-allocate cache in front of the DRAM word bridge.
module dram_cache
  import dram_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        cpu_req,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_valid,
  output logic        cpu_written,
  output logic        dram_oe,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_we,
  input  logic [31:0] dram_rdata,
  input  logic        dram_valid,
  input  logic        dram_written,
  output logic        perf_hit,
  output logic        perf_miss
);

  localparam int LINES = 1 << INDEX_BITS;

  state_t                state_r;
  logic [31:0]           addr_r;
  logic [WORD_BITS-1:0]  cnt_r;
  logic [LINES-1:0]      valid_r;
  logic [31:0]           fill_word_r;

  logic [1:0]            off_s;
  logic [WORD_BITS-1:0]  word_s;
  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [INDEX_BITS-1:0] rd_idx_s;
  logic [WORD_BITS-1:0]  rd_word_s;
  logic [TAG_BITS-1:0]   ram_tag_s;
  logic [31:0]           ram_data_s;
  logic [WORD_BITS-1:0]  wr_word_s;
  logic [3:0]            wr_be_s;
  logic [31:0]           wr_data_s;
  logic                  tag_we_s;
  logic                  hit_s;
  logic                  last_s;
  logic [WORD_BITS-1:0]  cnt_nxt_s;
  lane_wr_t              lane_s;

  assign off_s     = addr_off(addr_r);
  assign word_s    = addr_word(addr_r);
  assign idx_s     = addr_index(addr_r);
  assign tag_s     = addr_tag(addr_r);
  assign hit_s     = valid_r[idx_s] && (ram_tag_s == tag_s);
  assign last_s    = (cnt_r == {WORD_BITS{1'b1}});
  assign cnt_nxt_s = cnt_r + WORD_BITS'(1);
  assign lane_s    = lane_merge(dram_wdata, dram_we, off_s);
  assign cpu_ready = (state_r == IDLE) && !flush;

  // In IDLE the RAM looks up the incoming address so LOOKUP/WR_ISSUE see its tag and data.
  always_comb begin
    if (state_r == IDLE) begin
      rd_idx_s  = addr_index(cpu_addr);
      rd_word_s = addr_word(cpu_addr);
    end else begin
      rd_idx_s  = idx_s;
      rd_word_s = word_s;
    end
  end

  // RAM write port: refill words from DRAM, or merged store bytes on a write hit.
  always_comb begin
    wr_word_s = cnt_r;
    wr_be_s   = 4'h0;
    wr_data_s = dram_rdata;
    tag_we_s  = 1'b0;
    if (!rstn) begin
      wr_be_s = 4'h0;
    end else if ((state_r == RF_WAIT) && dram_valid) begin
      wr_be_s  = 4'hF;
      tag_we_s = last_s;
    end else if ((state_r == WR_ISSUE) && hit_s) begin
      wr_word_s = word_s;
      wr_be_s   = lane_s.be;
      wr_data_s = lane_s.data;
    end else begin
      wr_be_s = 4'h0;
    end
  end

  dram_cache_ram u_ram (
    .clk     (clk),
    .rd_idx  (rd_idx_s),
    .rd_word (rd_word_s),
    .rd_tag  (ram_tag_s),
    .rd_data (ram_data_s),
    .wr_idx  (idx_s),
    .wr_word (wr_word_s),
    .wr_be   (wr_be_s),
    .wr_data (wr_data_s),
    .tag_we  (tag_we_s),
    .wr_tag  (tag_s)
  );

  // Control FSM; dram_oe is raised on entry to an *_ISSUE state so it is high exactly there.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      addr_r      <= 32'h0;
      cnt_r       <= '0;
      fill_word_r <= 32'h0;
      cpu_rdata   <= 32'h0;
      cpu_valid   <= 1'b0;
      cpu_written <= 1'b0;
      dram_oe     <= 1'b0;
      dram_addr   <= 32'h0;
      dram_wdata  <= 32'h0;
      dram_we     <= 4'h0;
      perf_hit    <= 1'b0;
      perf_miss   <= 1'b0;
    end else begin
      cpu_valid   <= 1'b0;
      cpu_written <= 1'b0;
      dram_oe     <= 1'b0;
      perf_hit    <= 1'b0;
      perf_miss   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (flush) begin
            valid_r <= '0;
          end else if (cpu_req) begin
            addr_r <= cpu_addr;
            if (cpu_we[0]) begin
              // dram_wdata/dram_we double as the latched store request.
              dram_addr  <= cpu_addr;
              dram_wdata <= cpu_wdata;
              dram_we    <= cpu_we;
              dram_oe    <= 1'b1;
              state_r    <= WR_ISSUE;
            end else begin
              state_r <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            cpu_rdata <= ram_data_s >> {off_s, 3'b000};
            cpu_valid <= 1'b1;
            perf_hit  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            perf_miss <= 1'b1;
            cnt_r     <= '0;
            dram_oe   <= 1'b1;
            dram_we   <= 4'h0;
            dram_addr <= {tag_s, idx_s, {WORD_BITS{1'b0}}, 2'b00};
            state_r   <= RF_ISSUE;
          end
        end
        RF_ISSUE: state_r <= RF_WAIT;
        RF_WAIT: begin
          if (dram_valid) begin
            if (cnt_r == word_s) fill_word_r <= dram_rdata;
            if (last_s) begin
              valid_r[idx_s] <= 1'b1;
              state_r        <= RF_RESP;
            end else begin
              cnt_r     <= cnt_nxt_s;
              dram_oe   <= 1'b1;
              dram_addr <= {tag_s, idx_s, cnt_nxt_s, 2'b00};
              state_r   <= RF_ISSUE;
            end
          end
        end
        RF_RESP: begin
          cpu_rdata <= fill_word_r >> {off_s, 3'b000};
          cpu_valid <= 1'b1;
          state_r   <= IDLE;
        end
        WR_ISSUE: state_r <= WR_WAIT;
        WR_WAIT: begin
          if (dram_written) begin
            cpu_written <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cache.sv
// Directed self-checking bench for dram_cache with a one-cycle-latency DRAM bridge model.
module tb_dram_cache;

  logic        clk = 1'b0;
  logic        rstn, flush, cpu_req;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_we;
  logic        cpu_ready, cpu_valid, cpu_written;
  logic [31:0] cpu_rdata;
  logic        dram_oe;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic [3:0]  dram_we;
  logic        dram_valid, dram_written;
  logic        perf_hit, perf_miss;

  int tests = 0;
  int fails = 0;

  // Bridge-model state: main writes mute/stray controls, the bridge writes the rest.
  logic        bridge_mute;
  int          stray_cnt;
  logic        stray_kind;
  int          stray_seen;
  int          oe_cnt;
  logic [31:0] oe_log [128];
  logic [3:0]  last_we;
  logic [31:0] last_wdata;
  logic        pend_rd, pend_wr;
  logic [31:0] pend_data;
  logic [31:0] dmem [int unsigned];

  always #5 clk = ~clk;

  dram_cache dut (
    .clk(clk), .rstn(rstn), .flush(flush), .cpu_req(cpu_req), .cpu_ready(cpu_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .cpu_valid(cpu_valid), .cpu_written(cpu_written), .dram_oe(dram_oe),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
    .dram_rdata(dram_rdata), .dram_valid(dram_valid), .dram_written(dram_written),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (dmem.exists(k)) return dmem[k];
    else return {16'hD000, a[15:2], 2'b00};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] w, d;
    logic [3:0]  be;
    w  = mem_rd(a);
    be = we << a[1:0];
    d  = wd << {a[1:0], 3'b000};
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    dmem[a >> 2] = w;
  endtask

  // DRAM bridge: answers each dram_oe one cycle later with a single-cycle done pulse.
  initial begin
    dram_valid = 1'b0; dram_written = 1'b0; dram_rdata = 32'h0;
    stray_seen = 0; oe_cnt = 0; pend_rd = 1'b0; pend_wr = 1'b0; pend_data = 32'h0;
    last_we = 4'h0; last_wdata = 32'h0;
    for (int i = 0; i < 4; i++) dmem[(32'h1230 >> 2) + i] = 32'hA0 + 32'(i);
    forever begin
      @(negedge clk); #1;
      dram_valid = 1'b0; dram_written = 1'b0;
      if (pend_rd) begin
        dram_valid = 1'b1; dram_rdata = pend_data; pend_rd = 1'b0;
      end else if (pend_wr) begin
        dram_written = 1'b1; pend_wr = 1'b0;
      end
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        if (stray_kind) dram_written = 1'b1;
        else begin dram_valid = 1'b1; dram_rdata = 32'hBAD0_BAD0; end
      end
      if (dram_oe === 1'b1) begin
        if (oe_cnt < 128) oe_log[oe_cnt] = dram_addr;
        oe_cnt++;
        last_we = dram_we; last_wdata = dram_wdata;
        if (dram_we == 4'h0) begin
          pend_data = mem_rd(dram_addr); pend_rd = !bridge_mute;
        end else begin
          mem_wr(dram_addr, dram_wdata, dram_we); pend_wr = !bridge_mute;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 80 && cpu_ready !== 1'b1; k++) @(negedge clk);
    chk("ready", 32'(cpu_ready), 32'h1);
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] data, output int lat,
                          output logic hit, output logic miss, output int nv);
    wait_ready();
    cpu_addr = a; cpu_we = 4'h0; cpu_wdata = 32'h0; cpu_req = 1'b1;
    data = 32'h0; lat = -1; hit = 1'b0; miss = 1'b0; nv = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      hit  = hit | perf_hit;
      miss = miss | perf_miss;
      if (cpu_valid) begin
        nv++;
        if (lat < 0) begin lat = k; data = cpu_rdata; end
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                           output int nw);
    int lat;
    lat = -1; nw = 0;
    wait_ready();
    cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_req = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (cpu_written) begin
        nw++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
    cpu_we = 4'h0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        h, m;
    int          lat, nv, nw, base, cv, cw, co;

    rstn = 1'b0; flush = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    cpu_we = 4'h0; bridge_mute = 1'b0; stray_cnt = 0; stray_kind = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 32'h1);
    chk("rst_valid", 32'(cpu_valid), 32'h0);
    chk("rst_written", 32'(cpu_written), 32'h0);
    chk("rst_oe", 32'(dram_oe), 32'h0);
    chk("rst_dram_we", 32'(dram_we), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_perf", {30'h0, perf_hit, perf_miss}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Cold read: full line refill, word 1 returned.
    base = oe_cnt;
    cpu_read(32'h0000_1234, d, lat, h, m, nv);
    chk("cold_oe_cnt", 32'(oe_cnt - base), 32'd4);
    for (int i = 0; i < 4; i++) chk("cold_oe_addr", oe_log[base + i], 32'h1230 + 32'(4 * i));
    chk("cold_rdata", d, 32'h0000_00A1);
    chk("cold_nvalid", 32'(nv), 32'd1);
    chk("cold_perf", {30'h0, h, m}, 32'h1);

    // Hit on the refilled line: two-cycle latency, no DRAM access.
    base = oe_cnt;
    cpu_read(32'h0000_1238, d, lat, h, m, nv);
    chk("hit_oe_cnt", 32'(oe_cnt - base), 32'd0);
    chk("hit_latency", 32'(lat), 32'd2);
    chk("hit_rdata", d, 32'h0000_00A2);
    chk("hit_perf", {30'h0, h, m}, 32'h2);

    // Byte store on a hit: forwarded unchanged, merged into the line.
    base = oe_cnt;
    cpu_write(32'h0000_1235, 32'h0000_0055, 4'b0001, nw);
    chk("st_oe_cnt", 32'(oe_cnt - base), 32'd1);
    chk("st_addr", oe_log[base], 32'h0000_1235);
    chk("st_we", 32'(last_we), 32'h1);
    chk("st_wdata", last_wdata, 32'h0000_0055);
    chk("st_written", 32'(nw), 32'd1);
    base = oe_cnt;
    cpu_read(32'h0000_1234, d, lat, h, m, nv);
    chk("merge_rdata", d, 32'h0000_55A1);
    chk("merge_oe_cnt", 32'(oe_cnt - base), 32'd0);

    // Store miss does not allocate; the next read refills from DRAM.
    base = oe_cnt;
    cpu_write(32'h0000_8000, 32'h1234_5678, 4'b1111, nw);
    chk("stmiss_oe_cnt", 32'(oe_cnt - base), 32'd1);
    chk("stmiss_written", 32'(nw), 32'd1);
    base = oe_cnt;
    cpu_read(32'h0000_8000, d, lat, h, m, nv);
    chk("stmiss_rd_perf", {30'h0, h, m}, 32'h1);
    chk("stmiss_rd_oe", 32'(oe_cnt - base), 32'd4);
    chk("stmiss_rd_data", d, 32'h1234_5678);

    // Alias conflict on index 0x23.
    cpu_read(32'h0000_2234, d, lat, h, m, nv);
    chk("alias_perf", {30'h0, h, m}, 32'h1);
    chk("alias_rdata", d, 32'hD000_2234);
    base = oe_cnt;
    cpu_read(32'h0000_1234, d, lat, h, m, nv);
    chk("evict_perf", {30'h0, h, m}, 32'h1);
    chk("evict_oe_cnt", 32'(oe_cnt - base), 32'd4);
    chk("evict_rdata", d, 32'h0000_55A1);

    // Store at offset 3 with all lanes: only byte 3 survives the shift.
    cpu_write(32'h0000_1237, 32'hAABB_CCDD, 4'b1111, nw);
    chk("off3_written", 32'(nw), 32'd1);
    cpu_read(32'h0000_1234, d, lat, h, m, nv);
    chk("off3_word", d, 32'hDD00_55A1);
    cpu_read(32'h0000_1237, d, lat, h, m, nv);
    chk("off3_shift", d, 32'h0000_00DD);
    chk("off3_perf", {30'h0, h, m}, 32'h2);

    // Reset in the middle of a refill, then stray bridge pulses in IDLE.
    bridge_mute = 1'b1;
    wait_ready();
    cpu_addr = 32'h0000_4000; cpu_we = 4'h0; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int k = 0; k < 10 && dram_oe !== 1'b1; k++) @(negedge clk);
    chk("abort_oe_seen", 32'(dram_oe), 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; bridge_mute = 1'b0;
    stray_kind = 1'b0; stray_cnt++;
    @(negedge clk);
    stray_kind = 1'b1; stray_cnt++;
    cv = 0; cw = 0; co = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cv += int'(cpu_valid); cw += int'(cpu_written); co += int'(dram_oe);
    end
    chk("stray_valid", 32'(cv), 32'd0);
    chk("stray_written", 32'(cw), 32'd0);
    chk("stray_oe", 32'(co), 32'd0);
    chk("stray_ready", 32'(cpu_ready), 32'h1);
    cpu_read(32'h0000_1238, d, lat, h, m, nv);
    chk("postrst_perf", {30'h0, h, m}, 32'h1);
    chk("postrst_rdata", d, 32'h0000_00A2);
    cpu_read(32'h0000_1238, d, lat, h, m, nv);
    chk("postrst_hit", {30'h0, h, m}, 32'h2);

    // Flush beats a simultaneous request, then every read misses.
    flush = 1'b1; cpu_addr = 32'h0000_1238; cpu_we = 4'h0; cpu_req = 1'b1;
    #1;
    chk("flush_ready_low", 32'(cpu_ready), 32'h0);
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    cv = 0; co = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cv += int'(cpu_valid); co += int'(dram_oe);
    end
    chk("flush_no_accept", 32'(cv + co), 32'd0);
    cpu_read(32'h0000_1238, d, lat, h, m, nv);
    chk("flush_miss", {30'h0, h, m}, 32'h1);
    chk("flush_rdata", d, 32'h0000_00A2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_cache.md
Name: dram_cache

Overview:
Direct-mapped, write-through, no-write-allocate cache between the CPU data port and the DRAM word bridge. It consumes the bridge's word interface (dram_oe, dram_we, dram_valid, dram_written).
- Read hits are served locally.
- Read misses refill a full line with sequential single-word DRAM reads.
- Every store is forwarded to DRAM unchanged and also merged into the line on a hit.

Parameters:
INDEX_BITS, 8, log2 of line count (256 lines)
WORD_BITS, 2, log2 of words per line (4 words = 16 B)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active-low
flush  in  1  clear all valid bits; acted on only in IDLE
cpu_req  in  1  request strobe; accepted when cpu_req & cpu_ready
cpu_ready  out  1  high only in IDLE
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, LSB-aligned (unshifted)
cpu_we  in  4  byte enables, LSB-aligned; cpu_we[0]=0 means read
cpu_rdata  out  32  load data = word >> 8*addr[1:0]
cpu_valid  out  1  one-cycle pulse: cpu_rdata valid
cpu_written  out  1  one-cycle pulse: store completed in DRAM
dram_oe  out  1  one-cycle request pulse to bridge
dram_addr  out  32  bridge address
dram_wdata  out  32  bridge store data (LSB-aligned)
dram_we  out  4  bridge byte enables (LSB-aligned)
dram_rdata  in  32  bridge load data
dram_valid  in  1  bridge read-done pulse
dram_written  in  1  bridge write-done pulse
perf_hit  out  1  one-cycle pulse per read hit
perf_miss  out  1  one-cycle pulse per read miss

Behaviour:
- Address split: offset [1:0]; word [2+:WORD_BITS]; index next INDEX_BITS; tag = remaining upper bits.
- Storage:
  - Tag and data arrays use synchronous read. These arrays are not reset.
  - The valid vector is a register array, cleared on reset and on flush.
- Reset (rstn=0 at clk edge):
  - state <= IDLE; valid <= 0.
  - All pulses (cpu_valid, cpu_written, dram_oe, perf_*) <= 0; dram_we <= 0; cpu_rdata <= 0.
  - cpu_ready is 1 in the first cycle after reset.
  - Reset mid-refill or mid-write aborts the operation. Any late dram_valid or dram_written is ignored in IDLE.
- IDLE:
  - cpu_ready=1. Latch addr, wdata and we on acceptance.
  - If flush and cpu_req arrive together, flush wins and the request is not accepted (cpu_ready is 0 that cycle).
  - Read -> LOOKUP. Write (cpu_we[0]=1) -> WR_ISSUE.
- LOOKUP (read):
  - Hit = valid[idx] & tag match.
  - Hit: cpu_rdata = word >> 8*off and cpu_valid=1 on the next cycle; perf_hit pulses; then IDLE.
  - Latency: request accepted in cycle 0, cpu_valid high in cycle 2.
  - Miss: perf_miss pulses; word counter <= 0; go to RF_ISSUE.
- RF_ISSUE: dram_oe=1 for one cycle, dram_we=0, dram_addr={tag,idx,cnt,2'b00}. Go to RF_WAIT.
- RF_WAIT:
  - On dram_valid, write dram_rdata into data[idx][cnt].
  - If cnt is the last word: write the tag, set valid[idx], go to RF_RESP.
  - Otherwise cnt++ and go to RF_ISSUE.
- RF_RESP: cpu_rdata = line word[req_word] >> 8*off; cpu_valid=1; then IDLE.
- WR_ISSUE:
  - dram_oe=1 for one cycle; dram_addr, dram_wdata and dram_we are the latched request values.
  - If the line hits, merge bytes into data: lane mask = (we << off) truncated to 4 bits, data = wdata << 8*off. Bytes shifted past bit 31 are dropped.
  - A miss does not allocate. Go to WR_WAIT.
- WR_WAIT: on dram_written, cpu_written=1 for one cycle, then IDLE.
- Only one request is outstanding at a time. dram_oe is never asserted outside RF_ISSUE and WR_ISSUE.
- cpu_req outside IDLE is ignored; the requester must hold it until cpu_ready.
- Any dram_valid or dram_written pulse outside the matching wait state is ignored.

Decomposition:
- Shared package dram_cache_pkg holds:
  - the state enum (IDLE, LOOKUP, RF_ISSUE, RF_WAIT, RF_RESP, WR_ISSUE, WR_WAIT);
  - TAG_BITS = 32-2-WORD_BITS-INDEX_BITS;
  - address-field extract functions;
  - the byte-lane merge function.
- One natural sub-module, dram_cache_ram: sync-read, byte-write data RAM plus tag RAM, inferable as BRAM/LUTRAM. The FSM stays in the top module.

Test Plan:
- Cold read 0x0000_1234, DRAM model returns 0xA0..0xA3 at 0x1230..0x123C:
  - exactly 4 dram_oe pulses, at 0x1230, 0x1234, 0x1238, 0x123C;
  - cpu_valid once with rdata=0xA1; perf_miss=1.
- Repeat read 0x1238 -> no dram_oe; cpu_valid 2 cycles after acceptance; rdata=0xA2; perf_hit=1.
- Store byte we=0001, wdata=0x55, addr=0x1235 (hit):
  - dram_oe with addr=0x1235, we=0001, wdata=0x55; cpu_written after dram_written;
  - then read 0x1234 -> 0x0000_55A1 from cache, no DRAM access.
- Store to uncached 0x8000 -> DRAM write only; following read 0x8000 misses and refills.
- Alias conflict: read 0x1234, then read 0x1234 + (1<<(4+INDEX_BITS)) -> second read misses and evicts; re-read of 0x1234 misses again.
- Assert rstn=0 during RF_WAIT, then deliver a stray dram_valid -> no cpu_valid, valid[] all 0, cpu_ready=1; flush after fills makes every following read a miss.
